// File: rtl/pipeline_control_if.sv
// Control bundle between the fetch/hazard side and the pipeline controller.
// It carries the fetch handshake, the stage occupancy flags, the enables and the counters.
interface pipeline_control_if #(
   parameter int CNT_W = 32
);
   logic             i_valid;
   logic             i_ready;
   logic             hazard;
   logic             jmp;
   logic             mem_busy;
   logic             f_valid;
   logic             d_valid;
   logic             e_valid;
   logic             f_en;
   logic             d_en;
   logic             pc_load;
   logic             stall;
   logic             retire;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] retire_cnt;

   modport master (
      output i_valid, hazard, jmp, mem_busy,
      input  i_ready, f_valid, d_valid, e_valid, f_en, d_en,
             pc_load, stall, retire, stall_cnt, retire_cnt
   );

   modport slave (
      input  i_valid, hazard, jmp, mem_busy,
      output i_ready, f_valid, d_valid, e_valid, f_en, d_en,
             pc_load, stall, retire, stall_cnt, retire_cnt
   );
endinterface

// File: rtl/pipeline_control.sv
// Three-stage F/D/E pipeline controller: flush on taken jump, freeze on memory wait,
// bubble on hazard, and a REFILL window that discards fetches after a flush.
module pipeline_control #(
   parameter int REFILL_CYC = 1,
   parameter int CNT_W      = 32
) (
   input  logic               clk,
   input  logic               rst,
   pipeline_control_if.slave  bus
);

   typedef enum logic {RUN, REFILL} state_t;

   state_t           state_q, state_d;
   logic [3:0]       rcnt_q, rcnt_d;
   logic             f_q, f_d, d_q, d_d, e_q, e_d;
   logic [CNT_W-1:0] stall_cnt_q, retire_cnt_q;

   logic pc_load, i_ready, f_en, d_en, stall, retire;

   // Priority: refill window, flush, memory freeze, hazard bubble, advance.
   always_comb begin
      pc_load = 1'b0;
      i_ready = 1'b0;
      f_en    = 1'b0;
      d_en    = 1'b0;
      stall   = 1'b0;
      retire  = 1'b0;
      state_d = state_q;
      rcnt_d  = rcnt_q;
      f_d     = f_q;
      d_d     = d_q;
      e_d     = e_q;
      if (state_q == REFILL) begin
         i_ready = 1'b1;
         stall   = 1'b1;
         f_d     = 1'b0;
         d_d     = 1'b0;
         e_d     = 1'b0;
         rcnt_d  = rcnt_q - 4'd1;
         if (rcnt_q == 4'd1) state_d = RUN;
      end else if (e_q && bus.jmp && !bus.mem_busy) begin
         pc_load = 1'b1;
         retire  = 1'b1;
         f_d     = 1'b0;
         d_d     = 1'b0;
         e_d     = 1'b0;
         state_d = REFILL;
         rcnt_d  = 4'(REFILL_CYC);
      end else if (e_q && bus.mem_busy) begin
         stall = 1'b1;
      end else if (bus.hazard) begin
         stall  = 1'b1;
         retire = e_q;
         e_d    = 1'b0;
      end else begin
         i_ready = 1'b1;
         f_en    = 1'b1;
         d_en    = 1'b1;
         retire  = e_q;
         e_d     = d_q;
         d_d     = f_q;
         f_d     = bus.i_valid;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RUN;
         rcnt_q       <= 4'd0;
         f_q          <= 1'b0;
         d_q          <= 1'b0;
         e_q          <= 1'b0;
         stall_cnt_q  <= '0;
         retire_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         rcnt_q       <= rcnt_d;
         f_q          <= f_d;
         d_q          <= d_d;
         e_q          <= e_d;
         stall_cnt_q  <= stall_cnt_q + CNT_W'(stall);
         retire_cnt_q <= retire_cnt_q + CNT_W'(retire);
      end
   end

   assign bus.pc_load    = pc_load;
   assign bus.i_ready    = i_ready;
   assign bus.f_en       = f_en;
   assign bus.d_en       = d_en;
   assign bus.stall      = stall;
   assign bus.retire     = retire;
   assign bus.f_valid    = f_q;
   assign bus.d_valid    = d_q;
   assign bus.e_valid    = e_q;
   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_pipeline_control.sv
// Bench for pipeline_control: directed scenarios plus a randomized run, all checked
// against a stage-occupancy model built from the controller's rules.
module tb_pipeline_control;
   localparam int RC    = 2;
   localparam int CNT_W = 4;

   logic clk;
   logic rst;
   pipeline_control_if #(.CNT_W(CNT_W)) bus ();

   pipeline_control #(.REFILL_CYC(RC), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   // Model: m_v = {f,d,e} occupancy, m_ref = refill cycles still to go, counters mod 2^CNT_W.
   logic [2:0] m_v;
   int         m_ref, m_sc, m_rc;

   // Observed/expected per step: {pc_load,i_ready,f_en,d_en,stall,retire}.
   logic [5:0]       obs_c, exp_c;
   logic [2:0]       obs_v;
   logic [CNT_W-1:0] obs_sc, obs_rc;

   task automatic model_reset();
      m_v = 3'b000; m_ref = 0; m_sc = 0; m_rc = 0;
   endtask

   task automatic step(input logic iv, input logic hz, input logic jp, input logic mb);
      logic [2:0] nv;
      int         nref;
      bus.i_valid = iv; bus.hazard = hz; bus.jmp = jp; bus.mem_busy = mb;
      #1;
      obs_c = {bus.pc_load, bus.i_ready, bus.f_en, bus.d_en, bus.stall, bus.retire};
      nv = m_v; nref = m_ref;
      if (m_ref > 0) begin
         exp_c = 6'b010010; nv = 3'b000; nref = m_ref - 1;
      end else if (m_v[0] && jp && !mb) begin
         exp_c = 6'b100001; nv = 3'b000; nref = RC;
      end else if (m_v[0] && mb) begin
         exp_c = 6'b000010;
      end else if (hz) begin
         exp_c = {5'b00001, m_v[0]}; nv = {m_v[2:1], 1'b0};
      end else begin
         exp_c = {5'b01110, m_v[0]}; nv = {iv, m_v[2], m_v[1]};
      end
      @(posedge clk); #1;
      m_sc = (m_sc + int'(exp_c[1])) % (1 << CNT_W);
      m_rc = (m_rc + int'(exp_c[0])) % (1 << CNT_W);
      m_v = nv; m_ref = nref;
      obs_v  = {bus.f_valid, bus.d_valid, bus.e_valid};
      obs_sc = bus.stall_cnt;
      obs_rc = bus.retire_cnt;
   endtask

   task automatic do_reset();
      bus.i_valid = 0; bus.hazard = 0; bus.jmp = 0; bus.mem_busy = 0;
      rst = 1'b0;
      #1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      bus.i_valid = 1; bus.hazard = 0; bus.jmp = 1; bus.mem_busy = 0;
      @(posedge clk); #2;
      n_chk++; if ({bus.f_valid, bus.d_valid, bus.e_valid} !== 3'b000) $display("FAIL reset_valids got %b exp 000", {bus.f_valid, bus.d_valid, bus.e_valid}); else n_pass++;
      n_chk++; if (bus.stall_cnt !== 4'd0 || bus.retire_cnt !== 4'd0) $display("FAIL reset_counters got %0d/%0d exp 0/0", bus.stall_cnt, bus.retire_cnt); else n_pass++;
      n_chk++; if ({bus.pc_load, bus.retire, bus.stall} !== 3'b000) $display("FAIL reset_outputs got %b exp 000", {bus.pc_load, bus.retire, bus.stall}); else n_pass++;
   endtask

   task automatic test_fill();
      do_reset();
      step(1, 0, 0, 0);
      n_chk++; if (obs_v !== 3'b100) $display("FAIL fill_first_edge got %b exp 100", obs_v); else n_pass++;
      step(1, 0, 0, 0);
      step(1, 0, 0, 0);
      n_chk++; if (obs_v !== 3'b111) $display("FAIL fill_full got %b exp 111", obs_v); else n_pass++;
      step(1, 0, 0, 0);
      n_chk++; if (obs_c[0] !== 1'b1) $display("FAIL fill_retire got %b exp 1", obs_c[0]); else n_pass++;
      n_chk++; if (obs_rc !== 4'd1) $display("FAIL fill_retire_cnt got %0d exp 1", obs_rc); else n_pass++;
   endtask

   task automatic test_hazard();
      step(1, 1, 0, 0);
      n_chk++; if ({obs_c[4], obs_c[1]} !== 2'b01) $display("FAIL hazard1_ready_stall got %b exp 01", {obs_c[4], obs_c[1]}); else n_pass++;
      n_chk++; if (obs_v !== 3'b110) $display("FAIL hazard1_valids got %b exp 110", obs_v); else n_pass++;
      step(1, 1, 0, 0);
      n_chk++; if ({obs_c[4], obs_c[1], obs_c[0]} !== 3'b010) $display("FAIL hazard2_ready_stall_retire got %b exp 010", {obs_c[4], obs_c[1], obs_c[0]}); else n_pass++;
      n_chk++; if (obs_v !== 3'b110) $display("FAIL hazard2_valids got %b exp 110", obs_v); else n_pass++;
      n_chk++; if (obs_sc !== 4'd2) $display("FAIL hazard_stall_cnt got %0d exp 2", obs_sc); else n_pass++;
   endtask

   task automatic test_flush();
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      step(1, 0, 1, 0);
      n_chk++; if (obs_c[5] !== 1'b1) $display("FAIL flush_pc_load got %b exp 1", obs_c[5]); else n_pass++;
      n_chk++; if (obs_v !== 3'b000) $display("FAIL flush_valids got %b exp 000", obs_v); else n_pass++;
      for (int i = 0; i < RC; i++) begin
         step(1, 0, 1, 0);
         n_chk++; if ({obs_c[5], obs_c[4], obs_c[1]} !== 3'b011) $display("FAIL refill_outputs got %b exp 011", {obs_c[5], obs_c[4], obs_c[1]}); else n_pass++;
         n_chk++; if (obs_v !== 3'b000) $display("FAIL refill_discard got %b exp 000", obs_v); else n_pass++;
      end
      step(1, 0, 0, 0);
      n_chk++; if (obs_v !== 3'b100) $display("FAIL refill_exit_fetch got %b exp 100", obs_v); else n_pass++;
   endtask

   task automatic test_mem_freeze();
      logic [CNT_W-1:0] sc0;
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      sc0 = obs_sc;
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 1, 1);
         n_chk++; if ({obs_c[5], obs_c[1], obs_c[0]} !== 3'b010) $display("FAIL freeze_outputs got %b exp 010", {obs_c[5], obs_c[1], obs_c[0]}); else n_pass++;
         n_chk++; if (obs_v !== 3'b111) $display("FAIL freeze_valids got %b exp 111", obs_v); else n_pass++;
      end
      n_chk++; if (obs_sc !== CNT_W'(sc0 + 4'd3)) $display("FAIL freeze_stall_cnt got %0d exp %0d", obs_sc, CNT_W'(sc0 + 4'd3)); else n_pass++;
      step(1, 0, 1, 0);
      n_chk++; if (obs_c[5] !== 1'b1) $display("FAIL freeze_then_flush got %b exp 1", obs_c[5]); else n_pass++;
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 15; i++) step(0, 1, 0, 0);
      n_chk++; if (obs_sc !== 4'd15) $display("FAIL wrap_pre got %0d exp 15", obs_sc); else n_pass++;
      step(0, 1, 0, 0);
      n_chk++; if (obs_sc !== 4'd0) $display("FAIL wrap_post got %0d exp 0", obs_sc); else n_pass++;
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
      step(1, 1, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      #2;
      rst = 1'b0;
      bus.jmp = 0;
      #1;
      model_reset();
      n_chk++; if ({bus.f_valid, bus.d_valid, bus.e_valid} !== 3'b000) $display("FAIL async_valids got %b exp 000", {bus.f_valid, bus.d_valid, bus.e_valid}); else n_pass++;
      n_chk++; if (bus.stall_cnt !== 4'd0 || bus.retire_cnt !== 4'd0) $display("FAIL async_counters got %0d/%0d exp 0/0", bus.stall_cnt, bus.retire_cnt); else n_pass++;
      n_chk++; if (bus.stall !== 1'b0) $display("FAIL async_stall got %b exp 0", bus.stall); else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      #1;
      step(1, 0, 0, 0);
      n_chk++; if (obs_v !== 3'b100 || obs_c[4] !== 1'b1) $display("FAIL async_resume got v=%b rdy=%b exp v=100 rdy=1", obs_v, obs_c[4]); else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step(1'($urandom % 2), 1'($urandom % 4 == 0), 1'($urandom % 6 == 0), 1'($urandom % 4 == 0));
         n_chk++; if (obs_c !== exp_c) $display("FAIL rand_comb cyc %0d got %b exp %b", i, obs_c, exp_c); else n_pass++;
         n_chk++; if (obs_v !== m_v) $display("FAIL rand_valids cyc %0d got %b exp %b", i, obs_v, m_v); else n_pass++;
         n_chk++; if (obs_sc !== CNT_W'(m_sc) || obs_rc !== CNT_W'(m_rc)) $display("FAIL rand_counters cyc %0d got %0d/%0d exp %0d/%0d", i, obs_sc, obs_rc, m_sc, m_rc); else n_pass++;
      end
   endtask

   initial begin
      rst = 1'b0;
      bus.i_valid = 0; bus.hazard = 0; bus.jmp = 0; bus.mem_busy = 0;
      model_reset();
      test_reset();
      test_fill();
      test_hazard();
      test_flush();
      test_mem_freeze();
      test_wrap();
      test_async_reset();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
